// File: rtl/serial_monitor_if.sv
// Host-monitor bundle: UART rx/tx handshake, shared RAM ports and CPU control.
// master = the monitor, slave = UART, RAM and CPU side.
interface serial_monitor_if #(
  parameter int addr_width = 9
) ();
  logic                  received;
  logic [7:0]            rx_byte;
  logic [7:0]            tx_byte;
  logic                  transmit;
  logic                  is_transmitting;
  logic [addr_width-1:0] m_raddr;
  logic [addr_width-1:0] m_waddr;
  logic [7:0]            m_dwrite;
  logic                  m_write_en;
  logic [7:0]            dread;
  logic [addr_width-1:0] startaddr;
  logic                  cpu_start;
  logic                  cpu_halted;
  logic                  bus_cpu;

  modport master (
    input  received, rx_byte, is_transmitting, dread, cpu_halted,
    output tx_byte, transmit, m_raddr, m_waddr, m_dwrite, m_write_en,
           startaddr, cpu_start, bus_cpu
  );

  modport slave (
    output received, rx_byte, is_transmitting, dread, cpu_halted,
    input  tx_byte, transmit, m_raddr, m_waddr, m_dwrite, m_write_en,
           startaddr, cpu_start, bus_cpu
  );
endinterface

// File: rtl/serial_monitor.sv
// UART host monitor: load/dump RAM and start the CPU from byte commands.
// Define SERIAL_MONITOR_CHECKSUM_EN to reply to loads with the data byte sum.
module serial_monitor #(
  parameter int         addr_width = 9,
  parameter logic [7:0] ACK_BYTE   = 8'h2E
) (
  input logic             clk,
  input logic             rst,
  serial_monitor_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, ARG_HI, ARG_LO, ARG_LEN, LOAD_DATA, DUMP_ADDR, DUMP_WAIT,
    DUMP_DATA, GO, RUN, TX, TX_HOLD
  } state_t;

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] REP_H = 8'h48;
  localparam logic [7:0] REP_Q = 8'h3F;

  state_t                state_q, state_n, ret_q, ret_n;
  logic [7:0]            cmd_q, cmd_n;
  logic [addr_width-9:0] hi_q, hi_n;
  logic [addr_width-1:0] addr_q, addr_n;
  logic [8:0]            cnt_q, cnt_n;
  logic [7:0]            tx_byte_q, tx_byte_n;
  logic                  transmit_q, transmit_n;
  logic [addr_width-1:0] raddr_q, raddr_n;
  logic [addr_width-1:0] waddr_q, waddr_n;
  logic [7:0]            dwrite_q, dwrite_n;
  logic                  wen_q, wen_n;
  logic [addr_width-1:0] start_q, start_n;
  logic                  cpu_start_q, cpu_start_n;
  logic                  bus_cpu_q, bus_cpu_n;
  logic [7:0]            load_reply;

`ifdef SERIAL_MONITOR_CHECKSUM_EN
  logic [7:0] sum_q, sum_n;
  // reply includes the byte being written this cycle
  assign load_reply = sum_q + bus.rx_byte;
`else
  assign load_reply = ACK_BYTE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      cmd_q       <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      tx_byte_q   <= '0;
      transmit_q  <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      dwrite_q    <= '0;
      wen_q       <= 1'b0;
      start_q     <= '0;
      cpu_start_q <= 1'b0;
      bus_cpu_q   <= 1'b0;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_n;
      ret_q       <= ret_n;
      cmd_q       <= cmd_n;
      hi_q        <= hi_n;
      addr_q      <= addr_n;
      cnt_q       <= cnt_n;
      tx_byte_q   <= tx_byte_n;
      transmit_q  <= transmit_n;
      raddr_q     <= raddr_n;
      waddr_q     <= waddr_n;
      dwrite_q    <= dwrite_n;
      wen_q       <= wen_n;
      start_q     <= start_n;
      cpu_start_q <= cpu_start_n;
      bus_cpu_q   <= bus_cpu_n;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
      sum_q       <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n     = state_q;
    ret_n       = ret_q;
    cmd_n       = cmd_q;
    hi_n        = hi_q;
    addr_n      = addr_q;
    cnt_n       = cnt_q;
    tx_byte_n   = tx_byte_q;
    transmit_n  = 1'b0;
    raddr_n     = raddr_q;
    waddr_n     = waddr_q;
    dwrite_n    = dwrite_q;
    wen_n       = 1'b0;
    start_n     = start_q;
    cpu_start_n = 1'b0;
    bus_cpu_n   = bus_cpu_q;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    sum_n       = sum_q;
`endif
    case (state_q)
      IDLE: if (bus.received) begin
        if (bus.rx_byte == CMD_L || bus.rx_byte == CMD_D || bus.rx_byte == CMD_G) begin
          cmd_n   = bus.rx_byte;
          state_n = ARG_HI;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
          if (bus.rx_byte == CMD_L) sum_n = '0;
`endif
        end else begin
          tx_byte_n = REP_Q;
          ret_n     = IDLE;
          state_n   = TX;
        end
      end
      ARG_HI: if (bus.received) begin
        // only the low bits of hi that fit the address are kept
        hi_n    = bus.rx_byte[addr_width-9:0];
        state_n = ARG_LO;
      end
      ARG_LO: if (bus.received) begin
        addr_n = {hi_q, bus.rx_byte};
        if (cmd_q == CMD_G) begin
          start_n   = {hi_q, bus.rx_byte};
          bus_cpu_n = 1'b1;
          state_n   = GO;
        end else begin
          state_n = ARG_LEN;
        end
      end
      ARG_LEN: if (bus.received) begin
        cnt_n   = (bus.rx_byte == 8'd0) ? 9'd256 : {1'b0, bus.rx_byte};
        state_n = (cmd_q == CMD_L) ? LOAD_DATA : DUMP_ADDR;
      end
      LOAD_DATA: if (bus.received) begin
        waddr_n  = addr_q;
        dwrite_n = bus.rx_byte;
        wen_n    = 1'b1;
        addr_n   = addr_q + 1'b1;
        cnt_n    = cnt_q - 9'd1;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        sum_n    = sum_q + bus.rx_byte;
`endif
        if (cnt_q == 9'd1) begin
          tx_byte_n = load_reply;
          ret_n     = IDLE;
          state_n   = TX;
        end
      end
      DUMP_ADDR: begin
        raddr_n = addr_q;
        state_n = DUMP_WAIT;
      end
      DUMP_WAIT: state_n = DUMP_DATA;
      DUMP_DATA: begin
        tx_byte_n = bus.dread;
        addr_n    = addr_q + 1'b1;
        cnt_n     = cnt_q - 9'd1;
        ret_n     = (cnt_q == 9'd1) ? IDLE : DUMP_ADDR;
        state_n   = TX;
      end
      GO: begin
        cpu_start_n = 1'b1;
        state_n     = RUN;
      end
      RUN: if (bus.cpu_halted) begin
        bus_cpu_n = 1'b0;
        tx_byte_n = REP_H;
        ret_n     = IDLE;
        state_n   = TX;
      end
      TX: if (!bus.is_transmitting) begin
        transmit_n = 1'b1;
        state_n    = TX_HOLD;
      end
      // one idle cycle lets the transmitter's busy flag rise before we look again
      TX_HOLD: state_n = ret_q;
      default: state_n = IDLE;
    endcase
  end

  assign bus.tx_byte    = tx_byte_q;
  assign bus.transmit   = transmit_q;
  assign bus.m_raddr    = raddr_q;
  assign bus.m_waddr    = waddr_q;
  assign bus.m_dwrite   = dwrite_q;
  assign bus.m_write_en = wen_q;
  assign bus.startaddr  = start_q;
  assign bus.cpu_start  = cpu_start_q;
  assign bus.bus_cpu    = bus_cpu_q;
endmodule

// File: tb/tb_serial_monitor.sv
// Directed bench for serial_monitor: scoreboard queues of expected tx bytes and RAM writes.
module tb_serial_monitor;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_monitor_if #(.addr_width(AW)) bus ();
  serial_monitor #(.addr_width(AW), .ACK_BYTE(8'h2E)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [7:0] b; logic chk_ra; logic [AW-1:0] ra; } tx_exp_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_exp_t;
  tx_exp_t txq[$];
  wr_exp_t wrq[$];
  int checks = 0;
  int errors = 0;
  int starts = 0;

`ifdef SERIAL_MONITOR_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  // RAM with one-cycle synchronous read
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.m_write_en) mem[bus.m_waddr] <= bus.m_dwrite;
    bus.dread <= mem[bus.m_raddr];
  end

  // transmitter: busy for 4 cycles after each pulse, or while forced
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  logic prev_busy = 1'b0;
  always @(posedge clk) busy_cnt <= bus.transmit ? 4 : (busy_cnt > 0 ? busy_cnt - 1 : 0);
  assign bus.is_transmitting = force_busy || (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    tx_exp_t te;
    wr_exp_t we;
    if (!rst) begin
      if (bus.transmit) begin
        chk("tx_expected", 32'(txq.size() != 0), 1);
        chk("tx_while_busy", 32'(prev_busy), 0);
        if (txq.size() != 0) begin
          te = txq.pop_front();
          chk("tx_byte", 32'(bus.tx_byte), 32'(te.b));
          if (te.chk_ra) chk("dump_raddr", 32'(bus.m_raddr), 32'(te.ra));
        end
      end
      if (bus.m_write_en) begin
        chk("wr_expected", 32'(wrq.size() != 0), 1);
        chk("wr_while_cpu", 32'(bus.bus_cpu), 0);
        if (wrq.size() != 0) begin
          we = wrq.pop_front();
          chk("wr_addr", 32'(bus.m_waddr), 32'(we.a));
          chk("wr_data", 32'(bus.m_dwrite), 32'(we.d));
        end
      end
      if (bus.cpu_start) begin
        starts++;
        chk("start_with_bus", 32'(bus.bus_cpu), 1);
      end
    end
    prev_busy = bus.is_transmitting;
  end

  task automatic push_tx(input logic [7:0] b, input logic chk_ra, input logic [AW-1:0] ra);
    tx_exp_t e;
    e.b = b; e.chk_ra = chk_ra; e.ra = ra;
    txq.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.a = a; e.d = d;
    wrq.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.received = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((txq.size() != 0 || wrq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(txq.size() == 0 && wrq.size() == 0), 1);
    txq.delete();
    wrq.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_byte"},   32'(bus.tx_byte), 0);
    chk({tag, "_transmit"},  32'(bus.transmit), 0);
    chk({tag, "_raddr"},     32'(bus.m_raddr), 0);
    chk({tag, "_waddr"},     32'(bus.m_waddr), 0);
    chk({tag, "_dwrite"},    32'(bus.m_dwrite), 0);
    chk({tag, "_wen"},       32'(bus.m_write_en), 0);
    chk({tag, "_startaddr"}, 32'(bus.startaddr), 0);
    chk({tag, "_cpu_start"}, 32'(bus.cpu_start), 0);
    chk({tag, "_bus_cpu"},   32'(bus.bus_cpu), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.received   = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // load 3 bytes at 0x010
    push_wr(9'h010, 8'hAA); push_wr(9'h011, 8'hBB); push_wr(9'h012, 8'hCC);
    push_tx(CSUM ? 8'h31 : 8'h2E, 1'b0, '0);
    send(8'h4C); send(8'h00); send(8'h10); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    drain("load1_drain", 200);

    // dump them back; any extra byte trips tx_expected
    push_tx(8'hAA, 1'b1, 9'h010); push_tx(8'hBB, 1'b1, 9'h011);
    send(8'h44); send(8'h00); send(8'h10); send(8'h02);
    drain("dump1_drain", 200);
    repeat (20) @(negedge clk);

    // load across the top of the address space; excess hi bits ignored
    push_wr(9'h1FF, 8'h11); push_wr(9'h000, 8'h22);
    push_tx(CSUM ? 8'h33 : 8'h2E, 1'b0, '0);
    send(8'h4C); send(8'hFF); send(8'hFF); send(8'h02);
    send(8'h11); send(8'h22);
    drain("load_wrap_drain", 200);

    push_tx(8'h11, 1'b1, 9'h1FF); push_tx(8'h22, 1'b1, 9'h000);
    send(8'h44); send(8'h01); send(8'hFF); send(8'h02);
    drain("dump_wrap_drain", 200);

    // halt pulse outside RUN must not produce a reply
    @(negedge clk); bus.cpu_halted = 1'b1;
    @(negedge clk); bus.cpu_halted = 1'b0;
    repeat (10) @(negedge clk);

    // go at 0x100, rx ignored while running
    push_tx(8'h48, 1'b0, '0);
    send(8'h47); send(8'h01); send(8'h00);
    chk("go_startaddr", 32'(bus.startaddr), 32'h100);
    chk("go_bus_cpu",   32'(bus.bus_cpu), 1);
    chk("go_starts",    32'(starts), 1);
    send(8'h5A);
    repeat (20) @(negedge clk);
    chk("run_bus_cpu",  32'(bus.bus_cpu), 1);
    chk("run_no_reply", 32'(txq.size()), 1);
    @(negedge clk); bus.cpu_halted = 1'b1;
    @(negedge clk); bus.cpu_halted = 1'b0;
    drain("halt_drain", 100);
    chk("halt_bus_cpu", 32'(bus.bus_cpu), 0);
    chk("halt_starts",  32'(starts), 1);

    // unknown command
    push_tx(8'h3F, 1'b0, '0);
    send(8'h5A);
    drain("unknown_drain", 100);

    // reply held off by a long busy period
    force_busy = 1'b1;
    push_tx(8'h3F, 1'b0, '0);
    send(8'h5A);
    repeat (50) @(negedge clk);
    chk("busy_held", 32'(txq.size()), 1);
    force_busy = 1'b0;
    drain("busy_drain", 100);

    // reset in the middle of a load
    push_wr(9'h020, 8'h01); push_wr(9'h021, 8'h02);
    send(8'h4C); send(8'h00); send(8'h20); send(8'h03);
    send(8'h01); send(8'h02);
    drain("partial_load_drain", 100);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_tx(8'h3F, 1'b0, '0);
    send(8'h5A);
    drain("after_rst_drain", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_monitor.md
Name: serial_monitor

Overview:
- UART-side host monitor: the other end of the CPU's memory and control interface.
- Receives command bytes from the UART receiver and acts on them:
  - writes program bytes into the shared RAM write port;
  - dumps RAM contents back over the UART transmitter;
  - starts the CPU at a given address and reports when it halts.
- Owns the RAM ports while the CPU is idle and hands them to the CPU while it runs, via bus_cpu.

Parameters:
- addr_width, 9, RAM address width; must be 9..16.
- ACK_BYTE, 8'h2E, byte sent after a completed load.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- received  input  1  one-cycle pulse, rx_byte valid
- rx_byte  input  8  received byte
- tx_byte  output  8  byte to transmit
- transmit  output  1  one-cycle pulse requesting transmission
- is_transmitting  input  1  transmitter busy
- m_raddr  output  addr_width  RAM read address
- m_waddr  output  addr_width  RAM write address
- m_dwrite  output  8  RAM write data
- m_write_en  output  1  RAM write strobe, one cycle per byte
- dread  input  8  RAM read data
- startaddr  output  addr_width  CPU start address
- cpu_start  output  1  one-cycle start pulse to CPU
- cpu_halted  input  1  one-cycle pulse from CPU on HLT
- bus_cpu  output  1  1 = CPU owns RAM ports (external mux select)

Behaviour:
- Reset values: all outputs 0; internal state = IDLE.
- Reset mid-operation aborts any command, drops bus_cpu and discards partial arguments.
- Per-cycle defaults: transmit, m_write_en and cpu_start are 0 unless asserted in that cycle.
- rx bytes are consumed only on a received pulse. Bytes arriving in states that do not consume rx are dropped; this includes RUN and all TX states.
- Address is assembled as {hi[addr_width-9:0], lo}; excess hi bits are ignored.
- Address arithmetic wraps modulo 2^addr_width.
- len = 0 means 256 bytes.

Commands (first byte received in IDLE):
- 'L' 8'h4C: hi, lo, len, then len data bytes.
  - Each data byte is written at addr in the cycle after its received pulse: m_waddr=addr, m_dwrite=byte, m_write_en=1. addr then increments.
  - After the last byte, reply ACK_BYTE.
- 'D' 8'h44: hi, lo, len.
  - For each byte: drive m_raddr=addr. dread is valid 2 cycles later (states DUMP_ADDR, DUMP_WAIT, DUMP_DATA).
  - Capture dread, transmit it, increment addr, repeat len times.
  - No reply byte after the data.
- 'G' 8'h47: hi, lo.
  - Set startaddr, set bus_cpu=1, pulse cpu_start one cycle later, enter RUN.
  - In RUN: wait for cpu_halted, then set bus_cpu=0 and reply 8'h48 ('H').
- Any other first byte: reply 8'h3F ('?'), return to IDLE.

States:
- IDLE, ARG_HI, ARG_LO, ARG_LEN, LOAD_DATA, DUMP_ADDR, DUMP_WAIT, DUMP_DATA, GO, RUN, TX, TX_HOLD.

TX handshake:
- In TX, wait until is_transmitting=0, then drive tx_byte and pulse transmit.
- TX_HOLD lasts exactly one cycle, to cover transmitter busy-flag latency.
- Then go to the return state: IDLE, or DUMP_ADDR if dump bytes remain.

Bus ownership:
- While bus_cpu=1, m_write_en stays 0 and m_raddr/m_waddr hold their last values.
- cpu_halted is ignored when not in RUN.

Optional Feature:
- Macro: SERIAL_MONITOR_CHECKSUM_EN.
- Defined: the load reply is the 8-bit modulo-256 sum of all data bytes written, instead of ACK_BYTE. The sum clears at each 'L'.
- Undefined: the load reply is ACK_BYTE; no sum register exists.

Test Plan:
- rx 4C 00 10 03 AA BB CC → writes AA@0x010, BB@0x011, CC@0x012, one m_write_en each; tx 2E (with checksum macro: tx 31).
- After load, rx 44 00 10 02 → m_raddr 0x010 then 0x011; tx AA then BB; no extra byte.
- rx 4C 01 FF 02 11 22 (addr_width=9) → writes 11@0x1FF, 22@0x000 (wrap); tx ack.
- rx 47 01 00 → startaddr=0x100, bus_cpu=1, cpu_start pulse; cpu_halted pulse 20 cycles later → bus_cpu=0, tx 48; rx bytes during RUN ignored.
- rx 5A → tx 3F, return to IDLE. Then is_transmitting held 1 for 50 cycles during a reply → transmit stays 0 until it drops, then exactly one pulse.
- rst asserted mid-load after 2 of 3 data bytes → all outputs 0, IDLE; next rx 5A yields tx 3F.
